// File: rtl/input_shift_register_pkg.sv
// Shared types for the input shift register (ISR) and its companion output shifter.
// Provides shift direction, ISR FSM states, width and the 0-encodes-32 count decode.
package input_shift_register_pkg;

   localparam int ISR_WIDTH = 32;

   typedef enum logic {
      SHIFT_LEFT  = 1'b0,
      SHIFT_RIGHT = 1'b1
   } shift_dir_t;

   typedef enum logic {
      IDLE      = 1'b0,
      PUSH_WAIT = 1'b1
   } isr_state_t;

   // 5-bit instruction fields use 0 to mean a full 32-bit word.
   function automatic logic [5:0] decode_count(input logic [4:0] code);
      return (code == 5'd0) ? 6'd32 : {1'b0, code};
   endfunction

endpackage

// File: rtl/input_shift_register_if.sv
// Request/response bundle between the FSM instruction decoder, the ISR and the RX FIFO push port.
// master = decoder/FIFO side, slave = the ISR itself.
interface input_shift_register_if;
   import input_shift_register_pkg::*;

   logic [ISR_WIDTH-1:0] data_in;
   logic                 shift_en;
   logic [4:0]           bit_count;
   shift_dir_t           shiftdir;
   logic                 push_req;
   logic                 push_block;
   logic                 clear;
   logic                 autopush;
   logic [4:0]           push_thresh;
   logic                 fifo_full;

   logic                 fifo_push_en;
   logic [ISR_WIDTH-1:0] fifo_data;
   logic [ISR_WIDTH-1:0] isr;
   logic [5:0]           shift_count;
   logic                 stall;

   modport master (
      output data_in, shift_en, bit_count, shiftdir, push_req, push_block,
             clear, autopush, push_thresh, fifo_full,
      input  fifo_push_en, fifo_data, isr, shift_count, stall
   );

   modport slave (
      input  data_in, shift_en, bit_count, shiftdir, push_req, push_block,
             clear, autopush, push_thresh, fifo_full,
      output fifo_push_en, fifo_data, isr, shift_count, stall
   );

endinterface

// File: rtl/input_shift_register.sv
// Per-state-machine input shift register: shifts source bits in, counts them, pushes words to RX FIFO.
// Threshold autopush is built only when ISR_AUTOPUSH_EN is defined.
//
// state     | meaning
// IDLE      | accepting push / shift / clear requests (that priority order)
// PUSH_WAIT | word held in ISR waiting for RX FIFO space; FSM stalled
module input_shift_register
   import input_shift_register_pkg::*;
#(
   parameter int WIDTH = ISR_WIDTH
) (
   input logic                  clk,
   input logic                  rst,
   input_shift_register_if.slave bus
);

   if (WIDTH != ISR_WIDTH) begin : g_width_check
      $error("input_shift_register supports WIDTH = 32 only");
   end

   isr_state_t       state_q, state_d;
   logic [WIDTH-1:0] isr_q, isr_d;
   logic [5:0]       count_q, count_d;

   logic [5:0]       n_bits;
   logic [WIDTH-1:0] src_mask;
   logic [WIDTH-1:0] src_bits;
   logic [WIDTH-1:0] shifted;
   logic [6:0]       count_sum;
   logic [5:0]       count_shifted;
   logic             trig;
   logic             push_en;
   logic [WIDTH-1:0] push_data;
   logic             stall;

   // Shifts by 32 fall out naturally: the old ISR shifts fully away and the mask becomes all ones.
   always_comb begin
      n_bits    = decode_count(bus.bit_count);
      src_mask  = (WIDTH'(1) << n_bits) - WIDTH'(1);
      src_bits  = bus.data_in & src_mask;
      if (bus.shiftdir == SHIFT_RIGHT) begin
         shifted = (isr_q >> n_bits) | (src_bits << (6'd32 - n_bits));
      end else begin
         shifted = (isr_q << n_bits) | src_bits;
      end
      count_sum     = {1'b0, count_q} + {1'b0, n_bits};
      count_shifted = (count_sum > 7'd32) ? 6'd32 : count_sum[5:0];
   end

`ifdef ISR_AUTOPUSH_EN
   logic [5:0] thresh;
   assign thresh = decode_count(bus.push_thresh);
   assign trig   = bus.autopush && (count_shifted >= thresh);
`else
   logic unused_autopush;
   assign unused_autopush = ^{bus.autopush, bus.push_thresh};
   assign trig            = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      isr_d     = isr_q;
      count_d   = count_q;
      push_en   = 1'b0;
      push_data = isr_q;
      stall     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.push_req) begin
               if (!bus.fifo_full) begin
                  push_en = 1'b1;
                  isr_d   = '0;
                  count_d = '0;
               end else if (!bus.push_block) begin
                  isr_d   = '0;
                  count_d = '0;
               end else begin
                  stall   = 1'b1;
                  state_d = PUSH_WAIT;
               end
            end else if (bus.shift_en) begin
               if (trig && !bus.fifo_full) begin
                  push_en   = 1'b1;
                  push_data = shifted;
                  isr_d     = '0;
                  count_d   = '0;
               end else begin
                  isr_d   = shifted;
                  count_d = count_shifted;
                  if (trig) begin
                     stall   = 1'b1;
                     state_d = PUSH_WAIT;
                  end
               end
            end else if (bus.clear) begin
               isr_d   = '0;
               count_d = '0;
            end
         end
         PUSH_WAIT: begin
            if (bus.fifo_full) begin
               stall = 1'b1;
            end else begin
               push_en = 1'b1;
               isr_d   = '0;
               count_d = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         isr_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         isr_q   <= isr_d;
         count_q <= count_d;
      end
   end

   assign bus.fifo_push_en = push_en;
   assign bus.fifo_data    = push_data;
   assign bus.isr          = isr_q;
   assign bus.shift_count  = count_q;
   assign bus.stall        = stall;

endmodule

// File: tb/tb_input_shift_register.sv
// Self-checking bench for input_shift_register: directed scenarios plus randomized traffic
// compared against a word-level reference model of the ISR.
module tb_input_shift_register;
   import input_shift_register_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   input_shift_register_if bus ();

   input_shift_register #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_checks = 0;
   int          n_fails  = 0;

   logic [31:0] m_isr;
   int          m_cnt;
   bit          m_pend;

   logic        obs_push;
   logic        obs_stall;
   logic [31:0] obs_data;
   int          stall_cycles;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive_idle(input bit full);
      bus.data_in     = '0;
      bus.shift_en    = 1'b0;
      bus.bit_count   = '0;
      bus.shiftdir    = SHIFT_LEFT;
      bus.push_req    = 1'b0;
      bus.push_block  = 1'b0;
      bus.clear       = 1'b0;
      bus.autopush    = 1'b0;
      bus.push_thresh = '0;
      bus.fifo_full   = full;
   endtask

   // One clock of stimulus: drive after the falling edge, check against the model, advance.
   task automatic step(input bit sh, input bit [4:0] bc, input bit dir, input bit pr,
                       input bit pb, input bit cl, input bit ap, input bit [4:0] th,
                       input bit full, input bit [31:0] d);
      int              n, cnt, th_n;
      longint unsigned field;
      logic [31:0]     sh_val, e_data, nx_isr;
      bit              e_push, e_stall, ap_live, trig, nx_pend;
      int              nx_cnt;

      @(negedge clk);
      bus.data_in     = d;
      bus.shift_en    = sh;
      bus.bit_count   = bc;
      bus.shiftdir    = dir ? SHIFT_RIGHT : SHIFT_LEFT;
      bus.push_req    = pr;
      bus.push_block  = pb;
      bus.clear       = cl;
      bus.autopush    = ap;
      bus.push_thresh = th;
      bus.fifo_full   = full;
      #2;

      n     = (bc == 0) ? 32 : int'(bc);
      th_n  = (th == 0) ? 32 : int'(th);
      field = 64'(d) & ((64'd1 << n) - 64'd1);
      if (dir) sh_val = 32'(((field << 32) | 64'(m_isr)) >> n);
      else     sh_val = 32'((64'(m_isr) << n) | field);
      cnt = (m_cnt + n > 32) ? 32 : m_cnt + n;
`ifdef ISR_AUTOPUSH_EN
      ap_live = ap;
`else
      ap_live = 1'b0;
`endif
      trig = ap_live && (cnt >= th_n);

      e_push  = 1'b0;
      e_stall = 1'b0;
      e_data  = m_isr;
      nx_isr  = m_isr;
      nx_cnt  = m_cnt;
      nx_pend = m_pend;
      if (m_pend) begin
         if (full) e_stall = 1'b1;
         else begin
            e_push = 1'b1; nx_isr = 0; nx_cnt = 0; nx_pend = 1'b0;
         end
      end else if (pr) begin
         if (!full) begin
            e_push = 1'b1; nx_isr = 0; nx_cnt = 0;
         end else if (!pb) begin
            nx_isr = 0; nx_cnt = 0;
         end else begin
            e_stall = 1'b1; nx_pend = 1'b1;
         end
      end else if (sh) begin
         if (trig && !full) begin
            e_push = 1'b1; e_data = sh_val; nx_isr = 0; nx_cnt = 0;
         end else begin
            nx_isr = sh_val; nx_cnt = cnt;
            if (trig) begin
               e_stall = 1'b1; nx_pend = 1'b1;
            end
         end
      end else if (cl) begin
         nx_isr = 0; nx_cnt = 0;
      end

      check("isr_reg", bus.isr, m_isr);
      check("count_reg", 32'(bus.shift_count), 32'(m_cnt));
      check("push_en", 32'(bus.fifo_push_en), 32'(e_push));
      check("stall", 32'(bus.stall), 32'(e_stall));
      if (e_push) check("fifo_data", bus.fifo_data, e_data);
      obs_push  = bus.fifo_push_en;
      obs_stall = bus.stall;
      obs_data  = bus.fifo_data;

      @(posedge clk);
      m_isr  = nx_isr;
      m_cnt  = nx_cnt;
      m_pend = nx_pend;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      drive_idle(1'b0);
      m_isr = 0; m_cnt = 0; m_pend = 1'b0;
      #12;
      check("rst_isr", bus.isr, 32'h0);
      check("rst_count", 32'(bus.shift_count), 32'h0);
      check("rst_push", 32'(bus.fifo_push_en), 32'h0);
      check("rst_stall", 32'(bus.stall), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Left shifts build up a word LSB-first
      step(1, 5'd8, 0, 0, 0, 0, 0, 5'd0, 0, 32'hFFFF_FFAB);
      step(1, 5'd8, 0, 0, 0, 0, 0, 5'd0, 0, 32'h1234_56CD);
      check("left_isr", bus.isr, 32'h0000_ABCD);
      check("left_count", 32'(bus.shift_count), 32'd16);

      // bit_count 0 means 32: whole source replaces ISR
      step(1, 5'd0, 1, 0, 0, 0, 0, 5'd0, 0, 32'hDEAD_BEEF);
      check("right32_isr", bus.isr, 32'hDEAD_BEEF);
      check("right32_count", 32'(bus.shift_count), 32'd32);

      // Count saturates but data keeps moving
      step(1, 5'd4, 0, 0, 0, 0, 0, 5'd0, 0, 32'h0000_000F);
      check("sat_isr", bus.isr, 32'hEADB_EEFF);
      check("sat_count", 32'(bus.shift_count), 32'd32);

      // Autopush at threshold 8
      step(0, 5'd0, 0, 0, 0, 1, 0, 5'd0, 0, 32'h0);
      step(1, 5'd8, 0, 0, 0, 0, 1, 5'd8, 0, 32'h0000_005A);
`ifdef ISR_AUTOPUSH_EN
      check("ap_push", 32'(obs_push), 32'h1);
      check("ap_data", obs_data, 32'h0000_005A);
      check("ap_stall", 32'(obs_stall), 32'h0);
      check("ap_isr", bus.isr, 32'h0);
      check("ap_count", 32'(bus.shift_count), 32'd0);
`else
      check("ap_off_push", 32'(obs_push), 32'h0);
      check("ap_off_isr", bus.isr, 32'h0000_005A);
      check("ap_off_count", 32'(bus.shift_count), 32'd8);
`endif

      // Blocking push held off by a full FIFO for three cycles
      step(0, 5'd0, 0, 0, 0, 1, 0, 5'd0, 0, 32'h0);
      step(1, 5'd16, 0, 0, 0, 0, 0, 5'd0, 0, 32'hFFFF_1234);
      stall_cycles = 0;
      for (int i = 0; i < 3; i++) begin
         step(0, 5'd0, 0, 1, 1, 0, 0, 5'd0, 1, 32'h0);
         if (obs_stall) stall_cycles++;
      end
      step(0, 5'd0, 0, 1, 1, 0, 0, 5'd0, 0, 32'h0);
      check("blk_stall_cycles", 32'(stall_cycles), 32'd3);
      check("blk_push", 32'(obs_push), 32'h1);
      check("blk_data", obs_data, 32'h0000_1234);
      check("blk_stall_at_push", 32'(obs_stall), 32'h0);
      step(0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, 32'h0);
      check("blk_idle_after", 32'(obs_push), 32'h0);

      // Non-blocking push into a full FIFO drops the word
      step(1, 5'd12, 0, 0, 0, 0, 0, 5'd0, 0, 32'h0000_0ABC);
      step(0, 5'd0, 0, 1, 0, 0, 0, 5'd0, 1, 32'h0);
      check("drop_push", 32'(obs_push), 32'h0);
      check("drop_stall", 32'(obs_stall), 32'h0);
      check("drop_isr", bus.isr, 32'h0);

      // Asynchronous reset while a word is pending
      step(1, 5'd8, 0, 0, 0, 0, 0, 5'd0, 0, 32'h0000_0077);
      step(0, 5'd0, 0, 1, 1, 0, 0, 5'd0, 1, 32'h0);
      check("pend_stall", 32'(obs_stall), 32'h1);
      @(negedge clk);
      drive_idle(1'b1);
      #2 rst = 1'b1;
      #1;
      check("arst_stall", 32'(bus.stall), 32'h0);
      check("arst_isr", bus.isr, 32'h0);
      check("arst_count", 32'(bus.shift_count), 32'h0);
      m_isr = 0; m_cnt = 0; m_pend = 1'b0;
      #1 rst = 1'b0;
      step(0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, 32'h0);
      check("arst_no_push", 32'(obs_push), 32'h0);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         bit          r_sh, r_pr, r_cl, r_full;
         int          op;
         op     = int'($urandom_range(0, 9));
         r_pr   = (op == 0);
         r_sh   = (op >= 1 && op <= 7) || ($urandom_range(0, 7) == 0);
         r_cl   = (op == 8) || ($urandom_range(0, 7) == 0);
         r_full = ($urandom_range(0, 2) == 0);
         step(r_sh, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), r_pr,
              1'($urandom_range(0, 1)), r_cl, 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 31)), r_full, $urandom());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/input_shift_register.md
# input_shift_register

Input-direction counterpart of the PIO output shift register: per-state-machine ISR that shifts bits from the pin/source path into a 32-bit register, tracks the shift count, and pushes completed words into the RX FIFO. Sits between the FSM instruction decoder (IN, PUSH, MOV ISR) and the `fifo` push port. Supports explicit blocking/non-blocking PUSH and threshold autopush, and raises `stall` back to the FSM when the RX FIFO is full.

## Interface
- `WIDTH`, 32, ISR and data width; only 32 is supported.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `data_in`  in  32  shift source; the low `n` bits are used.
- `shift_en`  in  1  IN instruction: shift `bit_count` bits this cycle.
- `bit_count`  in  5  bits to shift, 0 encodes 32.
- `shiftdir`  in  1  0 = shift left (data enters at LSB), 1 = shift right (data enters at MSB).
- `push_req`  in  1  explicit PUSH instruction.
- `push_block`  in  1  with `push_req`: 1 = stall while FIFO full, 0 = drop.
- `clear`  in  1  zero ISR and count (MOV ISR, null).
- `autopush`  in  1  enable threshold autopush.
- `push_thresh`  in  5  autopush threshold, 0 encodes 32.
- `fifo_full`  in  1  RX FIFO full status.
- `fifo_push_en`  out  1  one-cycle push strobe to RX FIFO.
- `fifo_data`  out  32  word pushed; valid when `fifo_push_en`.
- `isr`  out  32  current ISR contents.
- `shift_count`  out  6  bits shifted in since last clear, 0..32.
- `stall`  out  1  FSM must hold current instruction this cycle.

## Operation
- States: IDLE, PUSH_WAIT. Reset: IDLE, `isr`=0, `shift_count`=0, `fifo_push_en`=0, `stall`=0.
- Request priority in IDLE: `push_req` > `shift_en` > `clear`; lower ones ignored that cycle.
- Shift (n = bit_count, 0→32): left: next_isr = (isr << n) | data_in[n-1:0]; right: next_isr = (isr >> n) | (data_in[n-1:0] << (32-n)); n=32 gives next_isr = data_in both directions. next_count = min(count+n, 32).
- Autopush: triggered when shift occurs, `autopush`=1 and next_count >= thresh (0→32). If `fifo_full`=0: `fifo_push_en`=1, `fifo_data`=next_isr (combinational), isr/count cleared at edge. If full: isr/count take next values, `stall`=1, go PUSH_WAIT.
- Explicit push: `fifo_full`=0 → push current `isr`, clear. Full and `push_block`=0 → no push, isr/count still cleared, no stall. Full and `push_block`=1 → `stall`=1, go PUSH_WAIT.
- PUSH_WAIT: `stall`=`fifo_full`; `shift_en`/`push_req`/`clear` ignored (FSM re-presents the held instruction). First cycle with `fifo_full`=0: `fifo_push_en`=1, `fifo_data`=`isr`, `stall`=0, clear isr/count, return IDLE.
- `stall` is combinational; never asserted in a cycle with `fifo_push_en`=1.

## Timing
- Shift, clear: result visible on `isr`/`shift_count` one cycle after request.
- Non-blocked push/autopush: `fifo_push_en` in request cycle; FIFO captures at same edge; zero stall cycles.
- Blocked push: stall cycles = cycles `fifo_full` stays high; push fires in first non-full cycle.
- `fifo_full` falling mid-request cycle resolves combinationally in that cycle.
- Async `rst` mid-PUSH_WAIT: pending word discarded, back to reset values immediately.
- Shift count saturates at 32; further shifts still modify `isr`.

## Configuration
- `ISR_AUTOPUSH_EN` defined: autopush logic as above.
- Undefined: `autopush`/`push_thresh` ignored, no threshold comparator; PUSH_WAIT entered only by blocking explicit push.

## Structure
- `types.svh` gains `shift_dir_t` (SHIFT_LEFT=0, SHIFT_RIGHT=1, shared with output shift register), `isr_state_t` (IDLE, PUSH_WAIT), and `ISR_WIDTH`=32.
- No sub-module; shifter and push control live in one module instantiated per FSM and in `test_wrapper`.

## Test plan
- Left shift 8 bits of 0xAB, then 8 of 0xCD → `isr`=0x0000ABCD, `shift_count`=16.
- Right shift `bit_count`=0 with `data_in`=0xDEADBEEF → `isr`=0xDEADBEEF, `shift_count`=32.
- Autopush thresh 8, FIFO not full, shift 8 bits 0x5A → same-cycle `fifo_push_en`, `fifo_data`=0x5A, next `isr`=0, `shift_count`=0, `stall` never high.
- Blocking push with `fifo_full` high 3 cycles, `isr`=0x1234 → `stall` high 3 cycles, push of 0x1234 on 4th, state IDLE.
- Non-blocking push with FIFO full → no `fifo_push_en`, no stall, `isr`=0 next cycle.
- Async `rst` during PUSH_WAIT → `stall`, `isr`, `shift_count` zero immediately; no push after FIFO drains.
